// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit feeder.
//   state_e      : FSM state encoding (IDLE=0, SHIFT=1, GAP=2), 2 bits
//   GapCyclesMax : largest supported number of idle bit-times between words
package serial_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam int unsigned GapCyclesMax = 15;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for a downstream bit-serial sequence detector.
// A word accepted on din is shifted out one bit per clock on x, starting the
// cycle after acceptance, optionally followed by GAP_CYCLES idle bit-times.
//
// Ports:
//   clk       : sole clock, rising edge
//   reset     : synchronous active-high reset (priority over abort)
//   din       : parallel word to serialize
//   din_valid : din holds a valid word
//   din_ready : block accepts din this cycle
//   abort     : synchronous flush of the word in progress (priority over accept)
//   x         : serial bit stream, driven straight from the shift register
//   x_valid   : x carries a data bit this cycle
//   last_bit  : x carries the final bit of the current word
//   busy      : FSM is not idle
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam int unsigned GapEff  = (GAP_CYCLES > GapCyclesMax) ? GapCyclesMax : GAP_CYCLES;
  localparam bit          HasGap  = (GapEff > 0);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);
  // Gap counter counts down to zero, so load one less than the cycle count.
  localparam logic [3:0]  GapLoad = 4'((GapEff > 0) ? GapEff - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             accept;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Output logic. The shift register is kept at zero outside SHIFT, so x is a
  // plain register bit and reads 0 in IDLE and GAP without extra gating.
  always_comb begin
    x_valid   = (state_q == StShift);
    last_bit  = x_valid && (cnt_q == '0);
    x         = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    busy      = (state_q != StIdle);
    din_ready = !reset && !abort && ((state_q == StIdle) || (last_bit && !HasGap));
  end

  assign accept = din_valid && din_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    if (abort) begin
      state_d = StIdle;
      shreg_d = '0;
      cnt_d   = '0;
      gap_d   = '0;
    end else if (accept) begin
      // Also taken on the last bit when there is no gap: back-to-back words.
      state_d = StShift;
      shreg_d = din;
      cnt_d   = CntLoad;
    end else begin
      case (state_q)
        StShift: begin
          if (cnt_q != '0) begin
            shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q - CntW'(1);
          end else begin
            shreg_d = '0;
            if (HasGap) begin
              state_d = StGap;
              gap_d   = GapLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StGap: begin
          if (gap_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder. Three instances cover the
// MSB-first/no-gap, LSB-first/no-gap and MSB-first/3-gap configurations.
// Stimulus pushes expected {x, last_bit} pairs into a per-instance queue; a
// monitor per instance pops and compares whenever x_valid is high.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic       rst0, dv0, ab0, rdy0, x0, xv0, lb0, bsy0;
  logic       rst1, dv1, ab1, rdy1, x1, xv1, lb1, bsy1;
  logic       rst2, dv2, ab2, rdy2, x2, xv2, lb2, bsy2;
  logic [7:0] din0, din1, din2;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .din(din0), .din_valid(dv0), .din_ready(rdy0),
    .abort(ab0), .x(x0), .x_valid(xv0), .last_bit(lb0), .busy(bsy0)
  );
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(rst1), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .abort(ab1), .x(x1), .x_valid(xv1), .last_bit(lb1), .busy(bsy1)
  );
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .reset(rst2), .din(din2), .din_valid(dv2), .din_ready(rdy2),
    .abort(ab2), .x(x2), .x_valid(xv2), .last_bit(lb2), .busy(bsy2)
  );

  function automatic void chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // Push the first n bits of w in shift order; last_bit expected on bit 7.
  task automatic push_word(input int k, input logic [7:0] w, input bit msb, input int n);
    for (int j = 0; j < n; j++) begin
      logic [1:0] e;
      e = {(msb ? w[7-j] : w[j]), (j == 7)};
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: {x, last_bit} encoded as 2*x + last_bit
  always @(negedge clk) begin
    if (mon_en) begin
      if (xv0) begin
        if (q0.size() == 0) chk_int("dut0_unexpected_bit", 1, 0);
        else chk_int("dut0_bit", int'({x0, lb0}), int'(q0.pop_front()));
      end else begin
        chk_int("dut0_idle_out", int'({x0, lb0}), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (xv1) begin
        if (q1.size() == 0) chk_int("dut1_unexpected_bit", 1, 0);
        else chk_int("dut1_bit", int'({x1, lb1}), int'(q1.pop_front()));
      end else begin
        chk_int("dut1_idle_out", int'({x1, lb1}), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (xv2) begin
        if (q2.size() == 0) chk_int("dut2_unexpected_bit", 1, 0);
        else chk_int("dut2_bit", int'({x2, lb2}), int'(q2.pop_front()));
      end else begin
        chk_int("dut2_idle_out", int'({x2, lb2}), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    {rst0, rst1, rst2} = 3'b111;
    {dv0, dv1, dv2}    = 3'b000;
    {ab0, ab1, ab2}    = 3'b000;
    din0 = 8'h00; din1 = 8'h00; din2 = 8'h00;

    // Reset: din_ready low while reset high, clean idle after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_ready0", rdy0, 1'b0);
    chk_bit("rst_ready1", rdy1, 1'b0);
    chk_bit("rst_ready2", rdy2, 1'b0);
    step();
    {rst0, rst1, rst2} = 3'b000;
    @(negedge clk);
    mon_en = 1'b1;
    chk_bit("rst_busy0", bsy0, 1'b0);
    chk_bit("rst_busy2", bsy2, 1'b0);
    chk_bit("rst_xvalid0", xv0, 1'b0);
    chk_bit("rst_ready_after0", rdy0, 1'b1);
    chk_bit("rst_ready_after1", rdy1, 1'b1);

    // A: 8'hA5 MSB first -> 1,0,1,0,0,1,0,1, last_bit on 8th
    step();
    din0 = 8'hA5; dv0 = 1'b1;
    push_word(0, 8'hA5, 1'b1, 8);
    step();
    dv0 = 1'b0; din0 = 8'h00;
    @(negedge clk);
    chk_bit("a_latency", xv0, 1'b1);
    chk_bit("a_ready_mid", rdy0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_bit("a_done_xvalid", xv0, 1'b0);
    chk_bit("a_done_busy", bsy0, 1'b0);
    chk_bit("a_done_ready", rdy0, 1'b1);

    // D: abort on 4th bit of 8'hFF with a same-cycle din_valid
    step();
    din0 = 8'hFF; dv0 = 1'b1;
    push_word(0, 8'hFF, 1'b1, 4);
    step();
    dv0 = 1'b0;
    repeat (3) step();
    ab0 = 1'b1; dv0 = 1'b1; din0 = 8'h0F;
    @(negedge clk);
    chk_bit("d_abort_bit_valid", xv0, 1'b1);
    chk_bit("d_abort_ready", rdy0, 1'b0);
    step();
    ab0 = 1'b0; dv0 = 1'b0;
    @(negedge clk);
    chk_bit("d_after_xvalid", xv0, 1'b0);
    chk_bit("d_after_busy", bsy0, 1'b0);
    chk_bit("d_after_ready", rdy0, 1'b1);
    step();
    @(negedge clk);
    chk_bit("d_not_accepted", xv0, 1'b0);

    // E: reset + abort + din_valid on 3rd bit of 8'hAA, then clean restart
    step();
    din0 = 8'hAA; dv0 = 1'b1;
    push_word(0, 8'hAA, 1'b1, 3);
    step();
    dv0 = 1'b0;
    repeat (2) step();
    rst0 = 1'b1; ab0 = 1'b1; dv0 = 1'b1; din0 = 8'hFF;
    @(negedge clk);
    chk_bit("e_ready_in_reset", rdy0, 1'b0);
    step();
    rst0 = 1'b0; ab0 = 1'b0; dv0 = 1'b0;
    @(negedge clk);
    chk_int("e_outs_zero", int'({x0, xv0, lb0, bsy0}), 0);
    chk_bit("e_ready_after", rdy0, 1'b1);
    step();
    din0 = 8'h81; dv0 = 1'b1;
    push_word(0, 8'h81, 1'b1, 8);
    step();
    dv0 = 1'b0;
    @(negedge clk);
    chk_bit("e_restart_latency", xv0, 1'b1);
    repeat (9) step();

    // B: LSB first, din_valid held with 8'h05 then 8'h80 -> 16 contiguous bits
    din1 = 8'h05; dv1 = 1'b1;
    push_word(1, 8'h05, 1'b0, 8);
    push_word(1, 8'h80, 1'b0, 8);
    step();
    din1 = 8'h80;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk_bit("b_xvalid", xv1, i < 16);
      chk_bit("b_ready", rdy1, (i == 7) || (i == 15) || (i == 16));
      chk_bit("b_busy", bsy1, i < 16);
      step();
      if (i == 7) dv1 = 1'b0;
    end

    // C: GAP_CYCLES=3, 8'hC3 then 8'h3C with din_valid held
    din2 = 8'hC3; dv2 = 1'b1;
    push_word(2, 8'hC3, 1'b1, 8);
    push_word(2, 8'h3C, 1'b1, 8);
    step();
    din2 = 8'h3C;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk_bit("c_xvalid", xv2, (i < 8) || ((i >= 12) && (i < 20)));
      chk_bit("c_ready", rdy2, i == 11);
      chk_bit("c_busy", bsy2, i != 11);
      step();
      if (i == 11) dv2 = 1'b0;
    end
    repeat (4) step();

    chk_int("q0_drained", q0.size(), 0);
    chk_int("q1_drained", q1.size(), 0);
    chk_int("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 SHALL have parameter GAP_CYCLES, default 0: idle bit-times inserted after each word, range 0..15.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge; one clock and one reset only, synchronous active-high reset.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port din, input, WIDTH: parallel word to serialize.
REQ-007 SHALL have port din_valid, input, 1: din holds a valid word.
REQ-008 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-009 SHALL have port abort, input, 1: synchronous flush of the word in progress.
REQ-010 SHALL have port x, output, 1: serial bit stream to the downstream sequence detector, registered.
REQ-011 SHALL have port x_valid, output, 1: x carries a data bit this cycle.
REQ-012 SHALL have port last_bit, output, 1: x carries the final bit of the current word.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement three states: IDLE, SHIFT, GAP.
REQ-015 SHALL accept a word on a rising edge where din_valid && din_ready; din is captured into a WIDTH-bit shift register and a bit counter is loaded with WIDTH-1.
REQ-016 SHALL present the first bit on x with x_valid=1 in the cycle after acceptance: latency 1 clock.
REQ-017 SHALL present one bit per clock for WIDTH consecutive cycles; order set by MSB_FIRST.
REQ-018 SHALL assert last_bit only in the cycle the counter equals 0 while in SHIFT.
REQ-019 SHALL drive din_ready = !reset && !abort && (state==IDLE || (state==SHIFT && last_bit && GAP_CYCLES==0)).
REQ-020 SHALL, on acceptance during last_bit (GAP_CYCLES==0), emit the new word's first bit in the next cycle with no bubble.
REQ-021 SHALL transition SHIFT->GAP after last_bit when GAP_CYCLES>0, holding GAP for exactly GAP_CYCLES cycles, then go to IDLE.
REQ-022 SHALL transition SHIFT->IDLE after last_bit when GAP_CYCLES==0 and no new word is accepted.
REQ-023 SHALL drive x=0, x_valid=0 and last_bit=0 in IDLE and GAP.
REQ-024 SHALL, on abort high at an edge, enter IDLE, clear the shift register and counter, and produce x_valid=0 in the following cycle; the bit already on x in the abort cycle remains valid.
REQ-025 SHALL ignore din_valid while din_ready=0; din need not be held stable after acceptance.
REQ-026 SHALL give reset priority over abort, and abort priority over acceptance.

Reset
REQ-027 SHALL, while reset is high at a rising edge, set state=IDLE, x=0, x_valid=0, last_bit=0, shift register=0, counter=0, gap counter=0.
REQ-028 SHALL hold din_ready=0 in any cycle where reset is high; busy=0 in the first cycle after reset.
REQ-029 SHALL treat reset mid-word as a full flush; no remaining bits of that word are ever emitted.

Structure
REQ-030 SHALL place the state encoding (IDLE=0, SHIFT=1, GAP=2, 2-bit) and the GAP_CYCLES range limit in shared package serial_pkg.
REQ-031 SHALL be one module with no sub-modules: state register, next-state logic and output logic in separate processes.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1: accept 8'hA5 -> x = 1,0,1,0,0,1,0,1 over cycles 1..8 after acceptance, last_bit only at cycle 8.
REQ-033 MSB_FIRST=0, din_valid held high with 8'h05 then 8'h80, GAP_CYCLES=0 -> 16 contiguous x_valid cycles: 1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1.
REQ-034 GAP_CYCLES=3: two words back-to-back -> exactly 3 cycles with x_valid=0 and din_ready=0 between them, then 1 IDLE cycle with din_ready=1.
REQ-035 abort asserted at bit 4 of 8'hFF -> x_valid=0 from the next cycle, din_ready=1 one cycle after abort; same-cycle din_valid is not accepted.
REQ-036 reset asserted at bit 3, together with abort and din_valid -> all outputs 0 next cycle, no word accepted, and the next word after reset starts cleanly at latency 1.
